wb_port_arbiter: RTL and testbench

- Shares the single wb_master between two requesters: port 0 for instruction fetch and port 1 for load/store.
- Each requester sees the same cmd/busy/rdata contract that wb_master itself presents.
- Requests are latched, then arbitrated by round-robin or fixed priority.
- The winning request is replayed onto wb_master as a one-cycle command, and the result is returned to the winning requester.

---
 rtl/wb_bus.sv | 14 +
 rtl/wb_arb_req_slot.sv | 53 +++++
 rtl/wb_port_arbiter.sv | 93 +++++++++
 tb/tb_wb_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus.sv
// wb_bus: shared Wishbone master command encoding and arbiter state encoding.
package wb_bus;
    typedef enum logic [1:0] {
        WISHBONE_CMD_NONE  = 2'd0,
        WISHBONE_CMD_LOAD  = 2'd1,
        WISHBONE_CMD_STORE = 2'd2
    } wb_command_t;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'b001,
        ARB_ISSUE = 3'b010,
        ARB_WAIT  = 3'b100
    } arb_state_t;
endpackage

// File: rtl/wb_arb_req_slot.sv
// wb_arb_req_slot: one requester's latched command, pending/in-flight flags and load result.
module wb_arb_req_slot
    import wb_bus::*;
(
    input  logic        clk,
    input  logic        rst,
    input  wb_command_t cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        issue,
    input  logic        done,
    input  logic [31:0] bus_rdata,
    output logic        pending,
    output logic        busy,
    output wb_command_t req_cmd,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wmask,
    output logic [31:0] rdata
);
    logic in_flight;

    assign busy = pending | in_flight;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            in_flight <= 1'b0;
            req_cmd   <= WISHBONE_CMD_NONE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
            rdata     <= '0;
        end else begin
            if (cmd != WISHBONE_CMD_NONE && !busy) begin
                pending   <= 1'b1;
                req_cmd   <= cmd;
                req_addr  <= addr;
                req_wdata <= wdata;
                req_wmask <= wmask;
            end
            if (issue) begin
                pending   <= 1'b0;
                in_flight <= 1'b1;
            end
            if (done) begin
                in_flight <= 1'b0;
                if (req_cmd == WISHBONE_CMD_LOAD) rdata <= bus_rdata;
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one wb_master between a fetch port (0) and a load/store port (1).
module wb_port_arbiter
    import wb_bus::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  wb_command_t p0_cmd_in,
    input  logic [31:0] p0_addr_in,
    input  logic [31:0] p0_wdata_in,
    input  logic [3:0]  p0_wmask_in,
    output logic        p0_busy_out,
    output logic [31:0] p0_rdata_out,
    input  wb_command_t p1_cmd_in,
    input  logic [31:0] p1_addr_in,
    input  logic [31:0] p1_wdata_in,
    input  logic [3:0]  p1_wmask_in,
    output logic        p1_busy_out,
    output logic [31:0] p1_rdata_out,
    output wb_command_t m_cmd_out,
    output logic [31:0] m_addr_out,
    output logic [31:0] m_wdata_out,
    output logic [3:0]  m_wmask_out,
    input  logic        m_busy_in,
    input  logic [31:0] m_rdata_in,
    output logic        grant_out
);
    arb_state_t  state, state_next;
    logic        grant, last_grant, pick, issue, done;
    logic [1:0]  pend;
    wb_command_t req_cmd   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];

    wb_arb_req_slot u_slot0 (
        .clk(clk_in), .rst(reset_in),
        .cmd(p0_cmd_in), .addr(p0_addr_in), .wdata(p0_wdata_in), .wmask(p0_wmask_in),
        .issue(issue && !grant), .done(done && !grant), .bus_rdata(m_rdata_in),
        .pending(pend[0]), .busy(p0_busy_out),
        .req_cmd(req_cmd[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rdata(p0_rdata_out)
    );

    wb_arb_req_slot u_slot1 (
        .clk(clk_in), .rst(reset_in),
        .cmd(p1_cmd_in), .addr(p1_addr_in), .wdata(p1_wdata_in), .wmask(p1_wmask_in),
        .issue(issue && grant), .done(done && grant), .bus_rdata(m_rdata_in),
        .pending(pend[1]), .busy(p1_busy_out),
        .req_cmd(req_cmd[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rdata(p1_rdata_out)
    );

    // on a tie, round-robin favours the port that did not win last time
    assign pick = &pend ? (FIXED_PRIORITY ? 1'b0 : ~last_grant) : pend[1];

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            ARB_IDLE:  state_next = |pend ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: begin
                issue      = 1'b1;
                state_next = ARB_WAIT;
            end
            ARB_WAIT:  begin
                done       = !m_busy_in;
                state_next = m_busy_in ? ARB_WAIT : ARB_IDLE;
            end
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= ARB_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && |pend) grant <= pick;
            if (done) last_grant <= grant;
        end
    end

    assign grant_out   = grant;
    assign m_cmd_out   = issue ? req_cmd[grant] : WISHBONE_CMD_NONE;
    assign m_addr_out  = issue ? req_addr[grant] : '0;
    assign m_wmask_out = issue ? req_wmask[grant] : '0;
    assign m_wdata_out = (state != ARB_IDLE) ? req_wdata[grant] : '0;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors against wb_port_arbiter with a simple wb_master model.
module tb_wb_port_arbiter;
    import wb_bus::*;

    logic        clk = 1'b0;
    logic        rst;
    wb_command_t p0_cmd, p1_cmd;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic        p0_busy, p1_busy;
    logic [31:0] p0_rdata, p1_rdata;
    wb_command_t m_cmd;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wmask;
    logic        m_busy = 1'b0;
    logic        grant;

    int n_vec = 0, n_bad = 0;
    int cyc = 0, t0 = 0, lat = 1, cnt = 0, ncmd = 0;
    logic glog [$];

    wb_port_arbiter dut (
        .clk_in(clk), .reset_in(rst),
        .p0_cmd_in(p0_cmd), .p0_addr_in(p0_addr), .p0_wdata_in(p0_wdata), .p0_wmask_in(p0_wmask),
        .p0_busy_out(p0_busy), .p0_rdata_out(p0_rdata),
        .p1_cmd_in(p1_cmd), .p1_addr_in(p1_addr), .p1_wdata_in(p1_wdata), .p1_wmask_in(p1_wmask),
        .p1_busy_out(p1_busy), .p1_rdata_out(p1_rdata),
        .m_cmd_out(m_cmd), .m_addr_out(m_addr), .m_wdata_out(m_wdata), .m_wmask_out(m_wmask),
        .m_busy_in(m_busy), .m_rdata_in(m_rdata), .grant_out(grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // wb_master model: busy for lat cycles after each command, logs which port it served
    always @(negedge clk) begin
        if (rst) cnt = 0;
        else if (m_cmd != WISHBONE_CMD_NONE) begin
            cnt = lat;
            ncmd++;
            glog.push_back(grant);
        end else if (cnt > 0) cnt--;
        m_busy = cnt != 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic go_to(input int n);
        while (cyc - t0 < n) step();
    endtask

    task automatic wait_low(input bit p);
        int n = 0;
        while ((p ? p1_busy : p0_busy) && n < 100) begin
            step();
            n++;
        end
        check("busy_timeout", 32'(n < 100), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic req(input bit p, input wb_command_t c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        if (p) begin p1_cmd = c; p1_addr = a; p1_wdata = d; p1_wmask = m; end
        else begin p0_cmd = c; p0_addr = a; p0_wdata = d; p0_wmask = m; end
    endtask

    initial begin
        int q0, q1, n;
        rst = 1'b1;
        req(0, WISHBONE_CMD_NONE, 0, 0, 0);
        req(1, WISHBONE_CMD_NONE, 0, 0, 0);
        m_rdata = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_p0_busy", p0_busy, 0);
        check("rst_p1_busy", p1_busy, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_m_cmd", m_cmd, WISHBONE_CMD_NONE);
        check("rst_grant", grant, 0);
        step();

        // single load, busy must be high for cycles 1..7
        lat = 5; m_rdata = 32'hDEADBEEF; ncmd = 0;
        req(0, WISHBONE_CMD_LOAD, 32'h100, 0, 0); t0 = cyc;
        step(); req(0, WISHBONE_CMD_NONE, 0, 0, 0);
        check("t1_busy_c1", p0_busy, 1);
        go_to(2);
        check("t1_mcmd", m_cmd, WISHBONE_CMD_LOAD);
        check("t1_maddr", m_addr, 32'h100);
        go_to(3);
        check("t1_mcmd_wait", m_cmd, WISHBONE_CMD_NONE);
        go_to(7);
        check("t1_busy_c7", p0_busy, 1);
        go_to(8);
        check("t1_busy_c8", p0_busy, 0);
        check("t1_rdata", p0_rdata, 32'hDEADBEEF);
        check("t1_p1_busy", p1_busy, 0);
        check("t1_p1_rdata", p1_rdata, 0);
        check("t1_ncmd", ncmd, 1);

        // simultaneous requests after reset: p0 first, then p1 store
        do_reset();
        lat = 2; m_rdata = 32'hCAFEF00D;
        req(0, WISHBONE_CMD_LOAD, 32'h0, 0, 0);
        req(1, WISHBONE_CMD_STORE, 32'h200, 32'h12345678, 4'hF); t0 = cyc;
        step(); req(0, WISHBONE_CMD_NONE, 0, 0, 0); req(1, WISHBONE_CMD_NONE, 0, 0, 0);
        go_to(2);
        check("t2_cmd0", m_cmd, WISHBONE_CMD_LOAD);
        check("t2_grant0", grant, 0);
        go_to(5);
        check("t2_p0_done", p0_busy, 0);
        check("t2_p0_rdata", p0_rdata, 32'hCAFEF00D);
        check("t2_wdata_idle", m_wdata, 0);
        go_to(6);
        check("t2_cmd1", m_cmd, WISHBONE_CMD_STORE);
        check("t2_grant1", grant, 1);
        check("t2_addr1", m_addr, 32'h200);
        check("t2_wdata1", m_wdata, 32'h12345678);
        check("t2_wmask1", m_wmask, 4'hF);
        go_to(7);
        check("t2_wait_cmd", m_cmd, WISHBONE_CMD_NONE);
        check("t2_wait_addr", m_addr, 0);
        check("t2_wait_wdata", m_wdata, 32'h12345678);
        go_to(8);
        check("t2_p1_busy_c8", p1_busy, 1);
        go_to(9);
        check("t2_p1_busy_c9", p1_busy, 0);
        check("t2_p1_rdata", p1_rdata, 0);

        // fairness: both ports re-request on every completion
        do_reset();
        lat = 1; glog.delete(); q0 = 0; q1 = 0; n = 0;
        while (!(q0 == 3 && q1 == 3 && !p0_busy && !p1_busy) && n < 300) begin
            p0_cmd = (!p0_busy && q0 < 3) ? WISHBONE_CMD_LOAD : WISHBONE_CMD_NONE;
            p1_cmd = (!p1_busy && q1 < 3) ? WISHBONE_CMD_STORE : WISHBONE_CMD_NONE;
            if (p0_cmd != WISHBONE_CMD_NONE) q0++;
            if (p1_cmd != WISHBONE_CMD_NONE) q1++;
            step();
            n++;
        end
        req(0, WISHBONE_CMD_NONE, 0, 0, 0); req(1, WISHBONE_CMD_NONE, 0, 0, 0);
        check("t3_timeout", 32'(n < 300), 1);
        check("t3_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            check($sformatf("t3_grant%0d", i), glog[i], i % 2);

        // command while busy is ignored
        do_reset();
        lat = 3; m_rdata = 32'h0BADF00D; ncmd = 0;
        req(0, WISHBONE_CMD_LOAD, 32'h40, 0, 0); t0 = cyc;
        step();
        check("t4_busy", p0_busy, 1);
        req(0, WISHBONE_CMD_STORE, 32'h80, 32'hFFFFFFFF, 4'hF);
        step(); req(0, WISHBONE_CMD_NONE, 0, 0, 0);
        check("t4_addr", m_addr, 32'h40);
        wait_low(0);
        repeat (4) step();
        check("t4_ncmd", ncmd, 1);
        check("t4_rdata", p0_rdata, 32'h0BADF00D);

        // back-to-back: new command in the cycle busy falls
        lat = 1; m_rdata = 32'h11112222;
        req(0, WISHBONE_CMD_LOAD, 32'h300, 0, 0);
        step(); req(0, WISHBONE_CMD_NONE, 0, 0, 0);
        wait_low(0);
        req(0, WISHBONE_CMD_LOAD, 32'h304, 0, 0); t0 = cyc;
        step(); req(0, WISHBONE_CMD_NONE, 0, 0, 0);
        check("t5_busy", p0_busy, 1);
        check("t5_rdata", p0_rdata, 32'h11112222);
        go_to(2);
        check("t5_cmd", m_cmd, WISHBONE_CMD_LOAD);
        check("t5_addr", m_addr, 32'h304);
        wait_low(0);

        // reset while waiting on wb_master, then p1 serviced normally
        lat = 10; m_rdata = 32'h33334444;
        req(0, WISHBONE_CMD_LOAD, 32'h400, 0, 0); t0 = cyc;
        step(); req(0, WISHBONE_CMD_NONE, 0, 0, 0);
        go_to(4);
        check("t6_busy_pre", p0_busy, 1);
        do_reset();
        check("t6_p0_busy", p0_busy, 0);
        check("t6_p1_busy", p1_busy, 0);
        check("t6_p0_rdata", p0_rdata, 0);
        check("t6_m_cmd", m_cmd, WISHBONE_CMD_NONE);
        check("t6_grant", grant, 0);
        lat = 2; m_rdata = 32'h55AA55AA;
        req(1, WISHBONE_CMD_LOAD, 32'h500, 0, 0); t0 = cyc;
        step(); req(1, WISHBONE_CMD_NONE, 0, 0, 0);
        go_to(2);
        check("t6_cmd", m_cmd, WISHBONE_CMD_LOAD);
        check("t6_addr", m_addr, 32'h500);
        check("t6_grant1", grant, 1);
        go_to(4);
        check("t6_p1_busy_c4", p1_busy, 1);
        go_to(5);
        check("t6_p1_busy_c5", p1_busy, 0);
        check("t6_p1_rdata", p1_rdata, 32'h55AA55AA);
        check("t6_p0_idle", p0_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
